// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: sequencer states, instruction field positions and opcode helpers
package cpu_sequencer_pkg;
  typedef enum logic [2:0] {SEQ_IDLE, SEQ_FETCH, SEQ_DECODE, SEQ_IMM, SEQ_OPER, SEQ_EXEC, SEQ_WB} seq_state_t;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;
  localparam int R1_MSB = 10;
  localparam int R1_LSB = 8;
  localparam int R2_MSB = 7;
  localparam int R2_LSB = 5;
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDI = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SUBI = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_ANDI = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_ORI  = 5'd8;
  localparam logic [4:0] OP_XOR  = 5'd9;
  localparam logic [4:0] OP_XORI = 5'd10;
  localparam logic [4:0] OP_CMP  = 5'd11;
  localparam logic [4:0] OP_CMPI = 5'd12;
  localparam logic [4:0] OP_LDI  = 5'd13;
  localparam logic [4:0] OP_LDA  = 5'd14;
  localparam logic [4:0] OP_LDW  = 5'd15;
  localparam logic [4:0] OP_JMP  = 5'd16;
  localparam logic [4:0] OP_RJMP = 5'd17;
  localparam logic [4:0] OP_BREQ = 5'd18;
  function automatic logic has_imm(input logic [4:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_CMPI,
                      OP_LDI, OP_LDA, OP_LDW, OP_JMP, OP_RJMP, OP_BREQ};
  endfunction
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/write-back control FSM owning PC and SREG
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic [2:0]  reg1_code,
  output logic [2:0]  reg2_code,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [4:0]  opcode,
  output logic [15:0] imm,
  output logic [15:0] mem_read_data,
  output logic [15:0] SREG_in,
  output logic        dne_tr,
  input  logic [15:0] SREG_out,
  input  logic        flag_update,
  input  logic [15:0] mem_write_val,
  input  logic [15:0] mem_write_addr,
  input  logic [15:0] reg_write_val,
  input  logic [2:0]  reg_write_code,
  input  logic [15:0] PC_jump_loc,
  input  logic [15:0] PC_jump_inc,
  input  logic        jump,
  input  logic        rjump,
  input  logic        mem_wb,
  input  logic        reg_wb,
  output logic [15:0] pc,
  output logic        busy,
  output logic [15:0] instr_cnt
);
  seq_state_t state, next;
  logic [OP_MSB:R2_LSB] ir;
  logic [15:0] pc_next;
  assign opcode = ir[OP_MSB:OP_LSB];
  // register codes are visible while the opcode word is still on the read bus
  assign reg1_code = state == SEQ_DECODE ? mem_rdata[R1_MSB:R1_LSB] : ir[R1_MSB:R1_LSB];
  assign reg2_code = state == SEQ_DECODE ? mem_rdata[R2_MSB:R2_LSB] : ir[R2_MSB:R2_LSB];
  assign busy = state != SEQ_IDLE;
  assign pc_next = jump ? PC_jump_loc : rjump ? pc + PC_jump_inc : pc + (has_imm(opcode) ? 16'd2 : 16'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SEQ_IDLE;
      pc <= RESET_PC;
      SREG_in <= '0;
      ir <= '0;
      imm <= '0;
      mem_read_data <= '0;
      instr_cnt <= '0;
    end else begin
      state <= next;
      if (state == SEQ_DECODE) ir <= mem_rdata[OP_MSB:R2_LSB];
      if (state == SEQ_IMM) imm <= mem_rdata;
      if (state == SEQ_OPER) mem_read_data <= mem_rdata;
      if (state == SEQ_WB) begin
        pc <= pc_next;
        instr_cnt <= instr_cnt + 16'd1;
        if (flag_update) SREG_in <= SREG_out;
      end
    end
  always_comb begin
    next = state;
    mem_addr = '0;
    mem_rd = 1'b0;
    mem_we = 1'b0;
    mem_wdata = '0;
    rf_we = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    dne_tr = 1'b0;
    case (state)
      SEQ_IDLE: next = run ? SEQ_FETCH : SEQ_IDLE;
      SEQ_FETCH: begin
        mem_addr = pc;
        mem_rd = 1'b1;
        next = SEQ_DECODE;
      end
      SEQ_DECODE: begin
        mem_rd = has_imm(mem_rdata[OP_MSB:OP_LSB]);
        mem_addr = mem_rd ? pc + 16'd1 : '0;
        next = mem_rd ? SEQ_IMM : SEQ_EXEC;
      end
      SEQ_IMM: begin
        mem_rd = opcode == OP_LDA;
        mem_addr = mem_rd ? mem_rdata : '0;
        next = mem_rd ? SEQ_OPER : SEQ_EXEC;
      end
      SEQ_OPER: next = SEQ_EXEC;
      SEQ_EXEC: begin
        dne_tr = 1'b1;
        next = SEQ_WB;
      end
      SEQ_WB: begin
        rf_we = reg_wb;
        rf_waddr = reg_write_code;
        rf_wdata = reg_write_val;
        mem_we = mem_wb;
        mem_addr = mem_write_addr;
        mem_wdata = mem_write_val;
        next = run ? SEQ_FETCH : SEQ_IDLE;
      end
      default: next = SEQ_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed tests; the bench plays memory and the execute stage
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic [15:0] mem_addr, mem_rdata, mem_wdata, rf_wdata, imm, mem_read_data, SREG_in, pc, instr_cnt;
  logic mem_rd, mem_we, rf_we, dne_tr, busy;
  logic [2:0] reg1_code, reg2_code, rf_waddr;
  logic [4:0] opcode;
  logic [15:0] SREG_out, mem_write_val, mem_write_addr, reg_write_val, PC_jump_loc, PC_jump_inc;
  logic [2:0] reg_write_code;
  logic flag_update, jump, rjump, mem_wb, reg_wb;
  logic [15:0] mem [0:65535];
  logic [15:0] tb_addr, tb_data;
  logic tb_we = 1'b0;
  int tests = 0, fails = 0;

  cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .reg1_code(reg1_code), .reg2_code(reg2_code),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .opcode(opcode), .imm(imm),
    .mem_read_data(mem_read_data), .SREG_in(SREG_in), .dne_tr(dne_tr), .SREG_out(SREG_out),
    .flag_update(flag_update), .mem_write_val(mem_write_val), .mem_write_addr(mem_write_addr),
    .reg_write_val(reg_write_val), .reg_write_code(reg_write_code), .PC_jump_loc(PC_jump_loc),
    .PC_jump_inc(PC_jump_inc), .jump(jump), .rjump(rjump), .mem_wb(mem_wb), .reg_wb(reg_wb),
    .pc(pc), .busy(busy), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  function automatic logic [15:0] iw(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b);
    return {op, a, b, 5'd0};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we = 1'b1;
    step();
    tb_we = 1'b0;
  endtask

  task automatic clr_exec();
    {SREG_out, mem_write_val, mem_write_addr, reg_write_val, PC_jump_loc, PC_jump_inc} = '0;
    reg_write_code = '0;
    {flag_update, jump, rjump, mem_wb, reg_wb} = '0;
  endtask

  task automatic start_one();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %h want 0", busy); end
    tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h want 0000", pc); end
    tests++; if ({mem_rd, mem_we, rf_we, dne_tr} !== 4'b0) begin fails++; $display("FAIL reset_strobes: got %b want 0000", {mem_rd, mem_we, rf_we, dne_tr}); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    tests++; if ({instr_cnt, SREG_in, imm} !== 48'h0) begin fails++; $display("FAIL reset_regs: got %h want 0", {instr_cnt, SREG_in, imm}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ldi();
    poke(16'h0000, iw(OP_LDI, 3'd2, 3'd0));
    poke(16'h0001, 16'h1234);
    clr_exec(); reg_wb = 1'b1; reg_write_code = 3'd2; reg_write_val = 16'h1234;
    start_one();
    tests++; if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL ldi_fetch: got %b/%h want 1/0000", mem_rd, mem_addr); end
    step();
    tests++; if ({mem_rd, mem_addr, reg1_code} !== {1'b1, 16'h0001, 3'd2}) begin fails++; $display("FAIL ldi_decode: got %b/%h/%0d want 1/0001/2", mem_rd, mem_addr, reg1_code); end
    step();
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL ldi_imm_rd: got %b want 0", mem_rd); end
    step();
    tests++; if ({dne_tr, imm, opcode} !== {1'b1, 16'h1234, OP_LDI}) begin fails++; $display("FAIL ldi_exec: got %b/%h/%0d want 1/1234/%0d", dne_tr, imm, opcode, OP_LDI); end
    step();
    tests++; if ({rf_we, rf_waddr, rf_wdata, dne_tr} !== {1'b1, 3'd2, 16'h1234, 1'b0}) begin fails++; $display("FAIL ldi_wb: got %b/%0d/%h/%b want 1/2/1234/0", rf_we, rf_waddr, rf_wdata, dne_tr); end
    step();
    tests++; if ({busy, pc, instr_cnt} !== {1'b0, 16'h0002, 16'd1}) begin fails++; $display("FAIL ldi_after: got %b/%h/%0d want 0/0002/1", busy, pc, instr_cnt); end
  endtask

  task automatic test_add();
    poke(16'h0002, iw(OP_ADD, 3'd1, 3'd2));
    clr_exec(); reg_wb = 1'b1; reg_write_code = 3'd1; reg_write_val = 16'h0000;
    flag_update = 1'b1; SREG_out = 16'h0003;
    start_one();
    step();
    tests++; if ({mem_rd, reg1_code, reg2_code} !== {1'b0, 3'd1, 3'd2}) begin fails++; $display("FAIL add_decode: got %b/%0d/%0d want 0/1/2", mem_rd, reg1_code, reg2_code); end
    step();
    tests++; if (dne_tr !== 1'b1) begin fails++; $display("FAIL add_exec: got %b want 1", dne_tr); end
    step();
    tests++; if ({rf_we, rf_waddr, rf_wdata, SREG_in} !== {1'b1, 3'd1, 16'h0000, 16'h0000}) begin fails++; $display("FAIL add_wb: got %b/%0d/%h/%h want 1/1/0000/0000", rf_we, rf_waddr, rf_wdata, SREG_in); end
    step();
    tests++; if ({pc, SREG_in, busy} !== {16'h0003, 16'h0003, 1'b0}) begin fails++; $display("FAIL add_after: got %h/%h/%b want 0003/0003/0", pc, SREG_in, busy); end
  endtask

  task automatic test_lda();
    poke(16'h0003, iw(OP_LDA, 3'd3, 3'd0));
    poke(16'h0004, 16'h0040);
    poke(16'h0040, 16'h00AA);
    clr_exec(); reg_wb = 1'b1; reg_write_code = 3'd3; reg_write_val = 16'h00AA;
    start_one();
    tests++; if ({mem_rd, mem_addr} !== {1'b1, 16'h0003}) begin fails++; $display("FAIL lda_fetch: got %b/%h want 1/0003", mem_rd, mem_addr); end
    step();
    tests++; if ({mem_rd, mem_addr} !== {1'b1, 16'h0004}) begin fails++; $display("FAIL lda_decode: got %b/%h want 1/0004", mem_rd, mem_addr); end
    step();
    tests++; if ({mem_rd, mem_addr} !== {1'b1, 16'h0040}) begin fails++; $display("FAIL lda_imm: got %b/%h want 1/0040", mem_rd, mem_addr); end
    step();
    tests++; if ({mem_rd, busy, dne_tr} !== 3'b010) begin fails++; $display("FAIL lda_oper: got %b want 010", {mem_rd, busy, dne_tr}); end
    step();
    tests++; if ({dne_tr, mem_read_data, imm} !== {1'b1, 16'h00AA, 16'h0040}) begin fails++; $display("FAIL lda_exec: got %b/%h/%h want 1/00aa/0040", dne_tr, mem_read_data, imm); end
    step();
    tests++; if ({rf_we, rf_wdata} !== {1'b1, 16'h00AA}) begin fails++; $display("FAIL lda_wb: got %b/%h want 1/00aa", rf_we, rf_wdata); end
    step();
    tests++; if ({busy, pc} !== {1'b0, 16'h0005}) begin fails++; $display("FAIL lda_after: got %b/%h want 0/0005", busy, pc); end
  endtask

  task automatic test_self_modify();
    poke(16'h0005, iw(OP_LDW, 3'd1, 3'd0));
    poke(16'h0006, 16'h0050);
    poke(16'h0007, iw(OP_JMP, 3'd0, 3'd0));
    poke(16'h0008, 16'h0050);
    poke(16'h0050, 16'h0000);
    clr_exec(); mem_wb = 1'b1; mem_write_addr = 16'h0050; mem_write_val = 16'h05C0;
    start_one();
    repeat (4) step();
    tests++; if ({mem_we, mem_rd, mem_addr, mem_wdata} !== {2'b10, 16'h0050, 16'h05C0}) begin fails++; $display("FAIL ldw_wb: got %b%b/%h/%h want 10/0050/05c0", mem_we, mem_rd, mem_addr, mem_wdata); end
    step();
    tests++; if (pc !== 16'h0007) begin fails++; $display("FAIL ldw_pc: got %h want 0007", pc); end
    clr_exec(); jump = 1'b1; PC_jump_loc = 16'h0050; rjump = 1'b1; PC_jump_inc = 16'h0010;
    start_one();
    repeat (5) step();
    tests++; if (pc !== 16'h0050) begin fails++; $display("FAIL jmp_prio: got %h want 0050", pc); end
    clr_exec(); flag_update = 1'b0;
    start_one();
    tests++; if (mem_addr !== 16'h0050) begin fails++; $display("FAIL smc_fetch: got %h want 0050", mem_addr); end
    step();
    tests++; if ({reg1_code, reg2_code} !== {3'd5, 3'd6}) begin fails++; $display("FAIL smc_word: got %0d/%0d want 5/6", reg1_code, reg2_code); end
    repeat (3) step();
    tests++; if (pc !== 16'h0051) begin fails++; $display("FAIL smc_pc: got %h want 0051", pc); end
  endtask

  task automatic test_branch();
    poke(16'h0051, iw(OP_BREQ, 3'd0, 3'd0));
    poke(16'h0052, 16'h0100);
    poke(16'h0100, iw(OP_CMP, 3'd1, 3'd2));
    poke(16'h0101, iw(OP_BREQ, 3'd0, 3'd0));
    poke(16'h0102, 16'h0100);
    clr_exec(); jump = 1'b1; PC_jump_loc = 16'h0100;
    start_one();
    repeat (5) step();
    tests++; if (pc !== 16'h0100) begin fails++; $display("FAIL breq_taken: got %h want 0100", pc); end
    clr_exec(); flag_update = 1'b1; SREG_out = 16'h0000;
    start_one();
    repeat (4) step();
    tests++; if ({pc, SREG_in} !== {16'h0101, 16'h0000}) begin fails++; $display("FAIL cmp_flags: got %h/%h want 0101/0000", pc, SREG_in); end
    clr_exec();
    start_one();
    repeat (5) step();
    tests++; if (pc !== 16'h0103) begin fails++; $display("FAIL breq_not_taken: got %h want 0103", pc); end
  endtask

  task automatic test_reset_mid();
    poke(16'h0103, iw(OP_LDA, 3'd4, 3'd0));
    poke(16'h0104, 16'h0040);
    clr_exec(); reg_wb = 1'b1; mem_wb = 1'b1; mem_write_addr = 16'h0060; reg_write_code = 3'd4;
    start_one();
    repeat (3) step();
    tests++; if ({busy, mem_rd, dne_tr} !== 3'b100) begin fails++; $display("FAIL rst_in_oper: got %b want 100", {busy, mem_rd, dne_tr}); end
    rst = 1'b1;
    #1;
    tests++; if ({busy, mem_rd, dne_tr, pc} !== {3'b000, 16'h0000}) begin fails++; $display("FAIL rst_async: got %b/%h want 000/0000", {busy, mem_rd, dne_tr}, pc); end
    step();
    tests++; if ({rf_we, mem_we, busy, instr_cnt} !== {3'b000, 16'd0}) begin fails++; $display("FAIL rst_held: got %b/%0d want 000/0", {rf_we, mem_we, busy}, instr_cnt); end
    rst = 1'b0;
    step();
    tests++; if ({rf_we, mem_we, busy, SREG_in} !== {3'b000, 16'h0000}) begin fails++; $display("FAIL rst_after: got %b/%h want 000/0000", {rf_we, mem_we, busy}, SREG_in); end
  endtask

  task automatic test_rjump_wrap();
    poke(16'h0000, iw(OP_RJMP, 3'd0, 3'd0));
    poke(16'h0001, 16'hFFFF);
    poke(16'hFFFF, iw(OP_NOP, 3'd0, 3'd0));
    clr_exec(); rjump = 1'b1; PC_jump_inc = 16'hFFFF;
    start_one();
    repeat (5) step();
    tests++; if (pc !== 16'hFFFF) begin fails++; $display("FAIL rjmp_wrap: got %h want ffff", pc); end
    clr_exec();
    start_one();
    tests++; if (mem_addr !== 16'hFFFF) begin fails++; $display("FAIL top_fetch: got %h want ffff", mem_addr); end
    repeat (4) step();
    tests++; if ({pc, instr_cnt} !== {16'h0000, 16'd2}) begin fails++; $display("FAIL pc_wrap: got %h/%0d want 0000/2", pc, instr_cnt); end
  endtask

  task automatic test_back_to_back();
    poke(16'h0000, iw(OP_NOP, 3'd0, 3'd0));
    poke(16'h0001, iw(OP_NOP, 3'd0, 3'd0));
    clr_exec(); reg_wb = 1'b1; reg_write_code = 3'd4; reg_write_val = 16'hBEEF;
    run = 1'b1;
    step();
    repeat (3) step();
    tests++; if ({rf_we, mem_rd} !== 2'b10) begin fails++; $display("FAIL b2b_wb1: got %b want 10", {rf_we, mem_rd}); end
    step();
    tests++; if ({mem_rd, mem_addr, busy} !== {1'b1, 16'h0001, 1'b1}) begin fails++; $display("FAIL b2b_fetch2: got %b/%h/%b want 1/0001/1", mem_rd, mem_addr, busy); end
    step(); step();
    tests++; if (dne_tr !== 1'b1) begin fails++; $display("FAIL b2b_exec2: got %b want 1", dne_tr); end
    run = 1'b0;
    step();
    tests++; if ({rf_we, rf_wdata, dne_tr} !== {1'b1, 16'hBEEF, 1'b0}) begin fails++; $display("FAIL drop_wb: got %b/%h/%b want 1/beef/0", rf_we, rf_wdata, dne_tr); end
    step();
    tests++; if ({busy, mem_rd, rf_we} !== 3'b000) begin fails++; $display("FAIL drop_idle: got %b want 000", {busy, mem_rd, rf_we}); end
    tests++; if ({pc, instr_cnt} !== {16'h0002, 16'd4}) begin fails++; $display("FAIL drop_counts: got %h/%0d want 0002/4", pc, instr_cnt); end
  endtask

  initial begin
    clr_exec();
    tb_addr = '0;
    tb_data = '0;
    test_reset();
    test_ldi();
    test_add();
    test_lda();
    test_self_modify();
    test_branch();
    test_reset_mid();
    test_rjump_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
